// File: rtl/cpu_pkg.sv
// Shared CPU pipeline constants: MEM/WB control-word bit positions and datapath defaults.
// Also used by the MEM/WB pipeline register and the forwarding unit, so the bit meanings agree everywhere.
package cpu_pkg;

  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  localparam int DW_DEF = 32;
  localparam int AW_DEF = 5;

  localparam int REG_ZERO = 0;

endpackage

// File: rtl/wb_regfile_if.sv
// Write-back / register-file bus: MEM/WB inputs, the ID-stage read ports and the status outputs.
// master drives the pipeline side, and slave is the wb_regfile.
interface wb_regfile_if #(
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int CNTW = 32
);

  logic [1:0]      i_WB;
  logic            i_overflow;
  logic [DW-1:0]   i_Dm;
  logic [DW-1:0]   i_result;
  logic [AW-1:0]   i_Rw;
  logic [AW-1:0]   ra_addr;
  logic [AW-1:0]   rb_addr;
  logic [DW-1:0]   ra_data;
  logic [DW-1:0]   rb_data;
  logic            wb_we;
  logic [AW-1:0]   wb_addr;
  logic [DW-1:0]   wb_data;
  logic            exc_ov;
  logic            exc_clr;
  logic [CNTW-1:0] retire_cnt;
  logic [CNTW-1:0] ov_cnt;

  modport master (
    output i_WB, i_overflow, i_Dm, i_result, i_Rw, ra_addr, rb_addr, exc_clr,
    input  ra_data, rb_data, wb_we, wb_addr, wb_data, exc_ov, retire_cnt, ov_cnt
  );

  modport slave (
    input  i_WB, i_overflow, i_Dm, i_result, i_Rw, ra_addr, rb_addr, exc_clr,
    output ra_data, rb_data, wb_we, wb_addr, wb_data, exc_ov, retire_cnt, ov_cnt
  );

endinterface

// File: rtl/regfile_2r1w.sv
// 2-read/1-write general register file with $0 hardwired to zero.
// Each read port has a same-cycle write-through bypass.
module regfile_2r1w
  import cpu_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] ra_addr,
  input  logic [AW-1:0] rb_addr,
  output logic [DW-1:0] ra_data,
  output logic [DW-1:0] rb_data
);

  localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

  logic [DW-1:0] regs [2**AW];

  // NOTE: the architectural reset clears every register, so this array is built from flops
  // rather than a RAM macro; a RAM cannot be cleared in a single cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**AW; i++) regs[i] <= '0;
    end else if (we && waddr != ZERO_ADDR) begin
      regs[waddr] <= wdata;
    end
  end

  // NOTE: each output gets a default before the priority chain, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    ra_data = '0;
    if (ra_addr == ZERO_ADDR)               ra_data = '0;
    else if (we && ra_addr == waddr)        ra_data = wdata;
    else                                    ra_data = regs[ra_addr];
  end

  always_comb begin
    rb_data = '0;
    if (rb_addr == ZERO_ADDR)               rb_data = '0;
    else if (we && rb_addr == waddr)        rb_data = wdata;
    else                                    rb_data = regs[rb_addr];
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: selects the result, gates the commit on overflow and $0, keeps the sticky
// overflow flag and the retire/overflow counters, and owns the register file.
module wb_regfile
  import cpu_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int AW   = AW_DEF,
  parameter int CNTW = 32
) (
  input  logic         clk,
  input  logic         rst,
  wb_regfile_if.slave  bus
);

  logic            reg_write;
  logic            retire_ev;
  logic            ov_ev;
  logic            exc_ov_q;
  logic [CNTW-1:0] retire_q;
  logic [CNTW-1:0] ov_q;

  assign reg_write = bus.i_WB[WB_REGWRITE];
  assign retire_ev = reg_write & ~bus.i_overflow;
  assign ov_ev     = reg_write &  bus.i_overflow;

  assign bus.wb_data = bus.i_WB[WB_MEMTOREG] ? bus.i_Dm : bus.i_result;
  assign bus.wb_addr = bus.i_Rw;
  // Writes to $0 still retire but are never architecturally visible, so they are masked from the
  // enable that forwarding and hazard logic observe.
  assign bus.wb_we   = retire_ev & (bus.i_Rw != AW'(REG_ZERO));

  regfile_2r1w #(.DW(DW), .AW(AW)) u_regs (
    .clk     (clk),
    .rst     (rst),
    .we      (bus.wb_we),
    .waddr   (bus.i_Rw),
    .wdata   (bus.wb_data),
    .ra_addr (bus.ra_addr),
    .rb_addr (bus.rb_addr),
    .ra_data (bus.ra_data),
    .rb_data (bus.rb_data)
  );

  // NOTE: state is updated with non-blocking assignments, so every flop samples the values from
  // before the edge no matter how the blocks are ordered.
  always_ff @(posedge clk) begin
    if (rst) begin
      exc_ov_q <= 1'b0;
      retire_q <= '0;
      ov_q     <= '0;
    end else begin
      if (retire_ev) retire_q <= retire_q + 1'b1;
      if (ov_ev)     ov_q     <= ov_q + 1'b1;
      // A new overflow wins over a simultaneous clear, so no exception is lost.
      if (ov_ev)             exc_ov_q <= 1'b1;
      else if (bus.exc_clr)  exc_ov_q <= 1'b0;
    end
  end

  assign bus.exc_ov     = exc_ov_q;
  assign bus.retire_cnt = retire_q;
  assign bus.ov_cnt     = ov_q;

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Consumer end of the MEM/WB pipeline register in the 5-stage pipelined CPU: write-back stage plus the 32x32 general register file.
- Selects the write-back data, ALU result or memory data, and commits it to the register file.
- Suppresses commits on arithmetic overflow, flags an overflow exception, and counts retired writes.
- Serves the two ID-stage read ports with same-cycle write-through bypass.

Parameters:
- DW, 32, data width.
- AW, 5, register address width; depth is 2**AW.
- CNTW, 32, width of the retire and exception counters.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- i_WB  in  2  write-back control: bit1 RegWrite, bit0 MemtoReg.
- i_overflow  in  1  ALU overflow for the instruction in WB.
- i_Dm  in  DW  data-memory read data.
- i_result  in  DW  ALU result.
- i_Rw  in  AW  destination register.
- ra_addr  in  AW  read port A address (ID stage).
- rb_addr  in  AW  read port B address (ID stage).
- ra_data  out  DW  read port A data (combinational).
- rb_data  out  DW  read port B data (combinational).
- wb_we  out  1  effective write enable this cycle (combinational; for forwarding and hazard logic).
- wb_addr  out  AW  effective write address (equals i_Rw).
- wb_data  out  DW  effective write data (combinational).
- exc_ov  out  1  sticky overflow exception flag.
- exc_clr  in  1  clears exc_ov.
- retire_cnt  out  CNTW  count of committed register writes.
- ov_cnt  out  CNTW  count of suppressed (overflowed) writes.

Behaviour:
- Data select: wb_data = i_WB[0] ? i_Dm : i_result.
- Write enable: wb_we = i_WB[1] & ~i_overflow & (i_Rw != 0).
- Commit: on posedge, if wb_we, regs[i_Rw] <= wb_data. Latency is 1 edge; the value is architecturally visible from the next cycle.
- Register $0: always reads 0 and is never written. Writes to $0 are dropped but still counted in retire_cnt when i_WB[1] is set and there is no overflow.
- Read ports: ra_data = (ra_addr==0) ? 0 : (wb_we && ra_addr==i_Rw) ? wb_data : regs[ra_addr]. Port B is identical. The write-through bypass removes the WB-to-ID hazard with no half-cycle clocking.
- Overflow: if i_WB[1] & i_overflow, the write is suppressed, ov_cnt increments and exc_ov is set on the next edge.
  - i_overflow with i_WB[1]=0 (e.g. store) has no effect.
- Flag precedence for exc_ov, highest first: rst clears; else set-event wins over exc_clr in the same cycle; else exc_clr clears.
- Retire: retire_cnt increments when i_WB[1] & ~i_overflow.
- Counters wrap modulo 2**CNTW silently.
- Reset (synchronous, checked at posedge):
  - all 32 registers, exc_ov, retire_cnt and ov_cnt go to 0.
  - rst dominates a simultaneous write, so no commit occurs in a reset cycle.
  - Combinational outputs still follow their inputs during reset; ra_data/rb_data reflect the zeroed file after the reset edge.
- Bubbles: an all-zero MEM/WB word (i_WB=0) is a NOP: no write, no counts.
- X-safety: i_Dm and i_result are don't-care when i_WB[1]=0, and must not propagate into state.

Decomposition:
- Shared package (cpu_pkg): WB_REGWRITE=1 and WB_MEMTOREG=0 bit indices, DW/AW defaults, and REG_ZERO=0.
- The MEM/WB register and forwarding unit use the same bit indices.
- One natural sub-module: regfile_2r1w (storage, two bypassed read ports, $0 hardwiring).
- wb_regfile keeps the mux, enable gating, exception flag and counters.

Test Plan:
- Reset then read all 32 addresses on both ports -> all 0; retire_cnt=0, ov_cnt=0, exc_ov=0.
- i_WB=2'b10, i_result=0x12345678, i_Rw=5 -> same cycle ra_addr=5 gives 0x12345678 (bypass); next cycle it comes from storage; retire_cnt=1.
- i_WB=2'b11, i_Dm=0xDEADBEEF, i_result=0x1, i_Rw=31 -> regs[31]=0xDEADBEEF.
- i_WB=2'b10, i_overflow=1, i_Rw=7 (regs[7] previously 0xA) -> regs[7] stays 0xA; ov_cnt=1; exc_ov=1.
  - exc_clr with a new overflow in the same cycle -> exc_ov stays 1.
  - exc_clr alone -> exc_ov=0.
- Write 0xFFFFFFFF to $0 -> ra_addr=0 reads 0 in that cycle and after; retire_cnt increments.
- rst asserted in the same cycle as a write to $9 -> regs[9]=0 after the edge.
- Preload retire_cnt near 2**CNTW-1, then two commits -> counter wraps to 0 then 1.
